// File: rtl/aes_pkg.sv
// Shared AES-128 constants, types and the round-constant table used by aes_ark_keystage.
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef logic [127:0] state_t;
  typedef logic [127:0] key_t;

  typedef enum logic [1:0] {StIdle, StLoad, StExpand, StRun} ark_state_e;

  // rcon[1..10]; any other index yields 0
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// 8-bit forward AES S-box as a constant lookup table.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [2047:0] SboxTab = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so offset is (255 - i) * 8
  assign o_byte = SboxTab[{~i_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_ark_keystage.sv
// AddRoundKey stage with on-the-fly AES-128 key schedule (forward and inverse stepping).
// Define AES_ARK_OUTREG_EN for a registered single-entry output; default is pass-through.
module aes_ark_keystage #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_key_load,
  input  logic [127:0] i_key_in,
  input  logic         i_dec,
  output logic         o_key_busy,
  input  logic [127:0] i_state_in,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  output logic [127:0] o_state_out,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [3:0]   o_round_idx,
  output logic         o_last_round
);

  import aes_pkg::*;

  if (NR != aes_pkg::NR) begin : g_nr_check
    $error("aes_ark_keystage supports only NR = 10 (AES-128)");
  end

  localparam logic [3:0] NrW = 4'(NR);

  ark_state_e r_state;
  logic       r_dec;
  key_t       r_key0, r_keyn, r_rk;
  logic [3:0] r_rnd, r_cnt;

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_sub_in, w_rot, w_sub, w_t;
  logic [31:0] w_f0, w_f1, w_f2, w_f3;
  logic [3:0]  w_rcon_idx;
  key_t        w_fwd, w_inv;
  logic        w_run, w_last, w_in_ready, w_accept;

  assign {w_w0, w_w1, w_w2, w_w3} = r_rk;
  assign w_run = (r_state == StRun);

  // Inverse stepping needs SubWord of the previous key's w3, i.e. w3 ^ w2
  assign w_sub_in = (r_dec && w_run) ? (w_w3 ^ w_w2) : w_w3;
  assign w_rot    = {w_sub_in[23:0], w_sub_in[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte(w_rot[8*g +: 8]),
      .o_byte(w_sub[8*g +: 8])
    );
  end

  always_comb begin
    w_rcon_idx = r_rnd + 4'd1;
    if (r_state == StExpand) w_rcon_idx = r_cnt;
    else if (r_dec)          w_rcon_idx = r_rnd;
  end

  assign w_t   = w_sub ^ {rcon(w_rcon_idx), 24'h0};
  assign w_f0  = w_w0 ^ w_t;
  assign w_f1  = w_w1 ^ w_f0;
  assign w_f2  = w_w2 ^ w_f1;
  assign w_f3  = w_w3 ^ w_f2;
  assign w_fwd = {w_f0, w_f1, w_f2, w_f3};
  assign w_inv = {w_w0 ^ w_t, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3 ^ w_w2};

  assign w_last = r_dec ? (r_rnd == 4'd0) : (r_rnd == NrW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_dec   <= 1'b0;
      r_key0  <= '0;
      r_keyn  <= '0;
      r_rk    <= '0;
      r_rnd   <= '0;
      r_cnt   <= '0;
    end else if (i_key_load) begin
      r_state <= StLoad;
      r_dec   <= i_dec;
      r_key0  <= i_key_in;
      r_rk    <= i_key_in;
    end else begin
      case (r_state)
        StLoad: begin
          if (r_dec) begin
            r_state <= StExpand;
            r_cnt   <= 4'd1;
          end else begin
            r_state <= StRun;
            r_rnd   <= 4'd0;
          end
        end
        StExpand: begin
          r_rk  <= w_fwd;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == NrW) begin
            r_keyn  <= w_fwd;
            r_rnd   <= NrW;
            r_state <= StRun;
          end
        end
        StRun: begin
          if (w_accept) begin
            if (!r_dec) begin
              if (r_rnd == NrW) begin
                r_rk  <= r_key0;
                r_rnd <= 4'd0;
              end else begin
                r_rk  <= w_fwd;
                r_rnd <= r_rnd + 4'd1;
              end
            end else begin
              if (r_rnd == 4'd0) begin
                r_rk  <= r_keyn;
                r_rnd <= NrW;
              end else begin
                r_rk  <= w_inv;
                r_rnd <= r_rnd - 4'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_key_busy = (r_state == StExpand);
  assign o_in_ready = w_in_ready;
  assign w_accept   = i_in_valid && w_in_ready;

`ifdef AES_ARK_OUTREG_EN
  logic         r_out_valid, r_last;
  logic [127:0] r_state_out;
  logic [3:0]   r_round_idx;

  assign w_in_ready = w_run && !i_key_load && (!r_out_valid || i_out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_state_out <= '0;
      r_round_idx <= '0;
      r_last      <= 1'b0;
    end else if (i_key_load) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_state_out <= i_state_in ^ r_rk;
      r_round_idx <= r_rnd;
      r_last      <= w_last;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid  = r_out_valid;
  assign o_state_out  = r_state_out;
  assign o_round_idx  = r_round_idx;
  assign o_last_round = r_last;
`else
  logic w_out_valid;

  assign w_in_ready   = w_run && !i_key_load && i_out_ready;
  assign w_out_valid  = i_in_valid && w_run && !i_key_load;
  assign o_out_valid  = w_out_valid;
  assign o_state_out  = w_out_valid ? (i_state_in ^ r_rk) : '0;
  assign o_round_idx  = w_run ? r_rnd : 4'd0;
  assign o_last_round = w_run && w_last;
`endif

endmodule

// File: tb/tb_aes_ark_keystage.sv
// Directed self-checking bench for aes_ark_keystage using the FIPS-197 A.1 key expansion.
module tb_aes_ark_keystage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_load, dec, key_busy;
  logic [127:0] key_in, state_in, state_out;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   round_idx;
  logic         last_round;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PAT = 128'h00112233445566778899aabbccddeeff;

  logic [127:0] rk_tab [11];

  aes_ark_keystage #(.NR(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_key_load   (key_load),
    .i_key_in     (key_in),
    .i_dec        (dec),
    .o_key_busy   (key_busy),
    .i_state_in   (state_in),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .o_state_out  (state_out),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_round_idx  (round_idx),
    .o_last_round (last_round)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // Called at posedge+1; returns at posedge+1 after the key_load edge.
  task automatic load_key(input logic [127:0] k, input logic d);
    key_in   = k;
    dec      = d;
    key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  // Offer one transfer and return what the output showed for it.
  task automatic xfer(input logic [127:0] st, output logic [127:0] so, output logic [3:0] ri,
                      output logic lr, output logic ov, output logic ok);
    state_in  = st;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    ok = 1'b0; so = '0; ri = '0; lr = 1'b0; ov = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
`ifndef AES_ARK_OUTREG_EN
        so = state_out; ri = round_idx; lr = last_round; ov = out_valid;
`endif
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
`ifdef AES_ARK_OUTREG_EN
    so = state_out; ri = round_idx; lr = last_round; ov = out_valid;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_load = 1'b0; dec = 1'b0; key_in = KEY;
    state_in = PAT; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    checks++;
    if (state_out !== 128'h0) begin
      errors++; $display("FAIL reset_state_out got %h exp 0", state_out);
    end
    checks++;
    if ({out_valid, in_ready, key_busy, last_round} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000", {out_valid, in_ready, key_busy, last_round});
    end
    checks++;
    if (round_idx !== 4'd0) begin
      errors++; $display("FAIL reset_round_idx got %0d exp 0", round_idx);
    end
    rst_n = 1'b1;
    @(posedge clk); #1; @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_ignore got rdy=%b vld=%b exp 0 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_encrypt();
    logic [127:0] so, st;
    logic [3:0] ri;
    logic lr, ov, ok;
    int r;
    load_key(KEY, 1'b0);
    // 13 transfers: a full block then the start of a back-to-back block
    for (int i = 0; i < 13; i++) begin
      r  = i % 11;
      st = (i < 11) ? 128'h0 : PAT;
      xfer(st, so, ri, lr, ov, ok);
      checks++;
      if (!ok || !ov || so !== (st ^ rk_tab[r]) || ri !== 4'(r) || lr !== (r == 10)) begin
        errors++;
        $display("FAIL enc_xfer%0d got so=%h idx=%0d last=%b vld=%b ok=%b exp so=%h idx=%0d last=%b",
                 i, so, ri, lr, ov, ok, st ^ rk_tab[r], r, (r == 10));
      end
    end
  endtask

  task automatic test_decrypt();
    logic [127:0] so;
    logic [3:0] ri;
    logic lr, ov, ok;
    int busy_cnt = 0;
    bit ready_seen = 0;
    out_ready = 1'b1;
    load_key(KEY, 1'b1);
    for (int n = 0; n < 40 && !ready_seen; n++) begin
      @(negedge clk);
      if (key_busy) busy_cnt++;
      if (in_ready) ready_seen = 1;
    end
    @(posedge clk); #1;
    checks++;
    if (!ready_seen || busy_cnt != 10) begin
      errors++; $display("FAIL dec_busy_cycles got %0d ready=%b exp 10", busy_cnt, ready_seen);
    end
    for (int i = 0; i < 11; i++) begin
      xfer(PAT, so, ri, lr, ov, ok);
      checks++;
      if (!ok || !ov || so !== (PAT ^ rk_tab[10-i]) || ri !== 4'(10 - i) || lr !== (i == 10)) begin
        errors++;
        $display("FAIL dec_xfer%0d got so=%h idx=%0d last=%b vld=%b ok=%b exp so=%h idx=%0d last=%b",
                 i, so, ri, lr, ov, ok, PAT ^ rk_tab[10-i], 10 - i, (i == 10));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] so, st;
    logic [3:0] ri;
    logic lr, ov, ok;
    // Continues straight after the decrypt block: keyN reused, no re-expansion
    for (int i = 0; i < 3; i++) begin
      st = ~PAT ^ 128'(i);
      xfer(st, so, ri, lr, ov, ok);
      checks++;
      if (!ok || so !== (st ^ rk_tab[10-i]) || ri !== 4'(10 - i) || key_busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_dec%0d got so=%h idx=%0d busy=%b ok=%b exp so=%h idx=%0d busy=0",
                 i, so, ri, key_busy, ok, st ^ rk_tab[10-i], 10 - i);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] so, st2, hold_so;
    logic [3:0] ri, hold_idx;
    logic lr, ov, ok;
    load_key(KEY, 1'b0);
    for (int i = 0; i < 3; i++) xfer(PAT, so, ri, lr, ov, ok);
    st2 = ~PAT;
`ifdef AES_ARK_OUTREG_EN
    hold_so  = PAT ^ rk_tab[2];
    hold_idx = 4'd2;
`else
    hold_so  = st2 ^ rk_tab[3];
    hold_idx = 4'd3;
`endif
    state_in  = st2;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || state_out !== hold_so ||
          round_idx !== hold_idx) begin
        errors++;
        $display("FAIL bp_hold%0d got rdy=%b vld=%b so=%h idx=%0d exp rdy=0 vld=1 so=%h idx=%0d",
                 c, in_ready, out_valid, state_out, round_idx, hold_so, hold_idx);
      end
      @(posedge clk); #1;
    end
    xfer(st2, so, ri, lr, ov, ok);
    checks++;
    if (!ok || so !== (st2 ^ rk_tab[3]) || ri !== 4'd3) begin
      errors++;
      $display("FAIL bp_release got so=%h idx=%0d ok=%b exp so=%h idx=3", so, ri, ok,
               st2 ^ rk_tab[3]);
    end
  endtask

  task automatic test_key_load_abort();
    logic [127:0] so;
    logic [3:0] ri;
    logic lr, ov, ok;
    load_key(KEY, 1'b0);
    for (int i = 0; i < 5; i++) xfer(128'h0, so, ri, lr, ov, ok);
    state_in  = PAT;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    key_in    = KEY;
    dec       = 1'b0;
    key_load  = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL abort_in_ready got %b exp 0", in_ready);
    end
    @(posedge clk); #1;
    key_load = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_out_valid got %b exp 0", out_valid);
    end
    xfer(PAT, so, ri, lr, ov, ok);
    checks++;
    if (!ok || so !== (PAT ^ rk_tab[0]) || ri !== 4'd0 || lr !== 1'b0) begin
      errors++;
      $display("FAIL abort_restart got so=%h idx=%0d last=%b ok=%b exp so=%h idx=0 last=0",
               so, ri, lr, ok, PAT ^ rk_tab[0]);
    end
  endtask

  task automatic test_reset_mid_expand();
    logic [127:0] so;
    logic [3:0] ri;
    logic lr, ov, ok;
    load_key(KEY, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (key_busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre_busy got %b exp 1", key_busy);
    end
    state_in  = PAT;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state_out !== 128'h0 || round_idx !== 4'd0 ||
        {out_valid, in_ready, key_busy, last_round} !== 4'b0) begin
      errors++;
      $display("FAIL rst_mid got so=%h idx=%0d flags=%b exp all 0", state_out, round_idx,
               {out_valid, in_ready, key_busy, last_round});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || key_busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_idle%0d got rdy=%b vld=%b busy=%b exp 0 0 0", c, in_ready, out_valid,
                 key_busy);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    load_key(KEY, 1'b0);
    xfer(PAT, so, ri, lr, ov, ok);
    checks++;
    if (!ok || so !== (PAT ^ rk_tab[0]) || ri !== 4'd0) begin
      errors++;
      $display("FAIL rst_reload got so=%h idx=%0d ok=%b exp so=%h idx=0", so, ri, ok,
               PAT ^ rk_tab[0]);
    end
  endtask

  initial begin
    rk_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    test_reset();
    test_encrypt();
    test_decrypt();
    test_back_to_back();
    test_backpressure();
    test_key_load_abort();
    test_reset_mid_expand();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
